branch_stat_counters: RTL and testbench
=======================================

BRANCH_STAT_COUNTERS -- requirements
Module: branch_stat_counters

Interface
REQ-001 SHALL have parameter SATURATE, default 1: 1 = counters hold at 0xFFFFFFFF; 0 = counters wrap to 0.
REQ-002 SHALL have input clk_core, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have input rstn, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input i_br_valid, 1 bit: one branch retired this cycle.
REQ-005 SHALL have input i_br_taken, 1 bit: the retiring branch was taken; it has meaning only when i_br_valid=1.
REQ-006 SHALL have Wishbone slave inputs i_wb_adr[4:0] (byte address), i_wb_dat[31:0], i_wb_sel[3:0], i_wb_we, i_wb_cyc and i_wb_stb.
REQ-007 SHALL have Wishbone slave outputs o_wb_rdt[31:0] and o_wb_ack (1 bit).
REQ-008 SHALL have outputs o_branches[31:0] and o_branches_taken[31:0]: live counter values for the display scanner.

Function
REQ-009 Register map, word-aligned (i_wb_adr[1:0] ignored):
- 0x00 BRANCHES (RO)
- 0x04 TAKEN (RO)
- 0x08 CTRL (RW)
- 0x0C reserved
- 0x10 SNAP_BR (RO)
- 0x14 SNAP_TK (RO)
- 0x18–0x1C reserved
REQ-010 CTRL bits:
- bit0 EN: RW, reset value 1.
- bit1 CLR: write-1 pulse, reads 0.
- bit2 SNAP: write-1 pulse, reads 0.
- bits[31:3]: read 0.
REQ-011 Bus access: o_wb_ack SHALL pulse high for exactly one cycle, in the cycle after i_wb_cyc&i_wb_stb is sampled high while o_wb_ack=0; a held strobe therefore gives an ack every second cycle.
REQ-012 Read data: o_wb_rdt SHALL be valid in the ack cycle; reads of reserved addresses return 0.
REQ-013 Writes SHALL take effect at the edge that raises o_wb_ack; only CTRL is writable; CTRL bits are updated only if i_wb_sel[0]=1.
REQ-014 Writes to RO or reserved addresses SHALL be acked and ignored.
REQ-015 When EN=1 and i_br_valid=1, BRANCHES SHALL increment by 1; if i_br_taken=1 as well, TAKEN SHALL also increment by 1, in the same cycle.
REQ-016 i_br_taken SHALL be ignored when i_br_valid=0.
REQ-017 No counter SHALL change when EN=0.
REQ-018 At 0xFFFFFFFF, a counter SHALL hold its value when SATURATE=1 and become 0x00000000 when SATURATE=0.
REQ-019 A CLR write SHALL zero both counters on its write edge; a branch event in that same cycle is discarded.
REQ-020 A SNAP write SHALL copy the pre-increment values of both counters into SNAP_BR/SNAP_TK; a concurrent increment still lands in the live counters.
REQ-021 CLR and SNAP set in the same write SHALL snapshot the old values and then clear the counters.
REQ-022 SNAP_BR/SNAP_TK SHALL change only on a SNAP write or on reset.
REQ-023 o_branches/o_branches_taken SHALL equal the BRANCHES/TAKEN registers directly, with zero latency after the edge that updates them.
REQ-024 Invariant: TAKEN <= BRANCHES at all times, except after BRANCHES has wrapped when SATURATE=0.

Reset
REQ-025 rstn=0 SHALL asynchronously set:
- all counters and snapshots to 0;
- EN to 1;
- o_wb_ack and o_wb_rdt to 0.
REQ-026 A bus cycle in progress when reset asserts SHALL be abandoned with no ack after release; the master re-issues it.
REQ-027 Counting SHALL resume on the first clk_core edge after rstn deasserts.

Structure
REQ-028 A shared package SHALL hold:
- register offsets (ADR_BRANCHES, ADR_TAKEN, ADR_CTRL, ADR_SNAP_BR, ADR_SNAP_TK);
- CTRL bit indices;
- the 32-bit counter max constant.
REQ-029 One sub-module, stat_counter32, SHALL be instantiated twice (inputs inc, clr, SATURATE; output 32-bit count).
REQ-030 The top level SHALL hold the Wishbone decode, the CTRL register and the snapshot registers.

Verification
REQ-031 Reset, then 10 cycles of valid=1 with taken alternating 1/0 → BRANCHES=10, TAKEN=5, and o_branches=10.
REQ-032 Write CTRL=0x0 (EN=0), then 5 valid=1 cycles → counters unchanged. Read CTRL → 0x0. Write CTRL=0x1 → counting resumes.
REQ-033 Force BRANCHES=0xFFFFFFFE and apply 3 valid=1 cycles → 0xFFFFFFFF with SATURATE=1, 0x00000001 with SATURATE=0.
REQ-034 Write CTRL=0x7 in the same cycle as valid=1, taken=1, with BRANCHES=20, TAKEN=7 → SNAP_BR=20, SNAP_TK=7, live counters=0.
REQ-035 Hold cyc/stb high for 6 cycles reading 0x00 → exactly 3 acks, each one cycle wide. Read 0x0C → 0.
REQ-036 Assert rstn=0 mid-transfer (after stb, before ack) → o_wb_ack stays 0, all registers return to reset values, EN=1.

Source files
------------

// File: rtl/branch_stat_counters_pkg.sv
// Shared definitions for the branch statistics block: register map,
// CTRL bit positions and the counter ceiling.
package branch_stat_counters_pkg;

    localparam logic [4:0] ADR_BRANCHES = 5'h00;
    localparam logic [4:0] ADR_TAKEN    = 5'h04;
    localparam logic [4:0] ADR_CTRL     = 5'h08;
    localparam logic [4:0] ADR_SNAP_BR  = 5'h10;
    localparam logic [4:0] ADR_SNAP_TK  = 5'h14;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_SNAP = 2;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Registers are word aligned, so only the word index takes part in decode.
    function automatic logic adr_hit(input logic [4:0] adr, input logic [4:0] reg_adr);
        return adr[4:2] == reg_adr[4:2];
    endfunction

endpackage

// File: rtl/stat_counter32.sv
// 32-bit event counter with synchronous clear and selectable saturate/wrap
// behaviour at the top of its range.
module stat_counter32
    import branch_stat_counters_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk_core,
    input  logic        rstn,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] r_count;

    // Clear wins over a same-cycle increment so a cleared counter reads exactly zero.
    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            if (SATURATE && (r_count == CNT_MAX)) begin
                r_count <= r_count;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign count = r_count;

endmodule

// File: rtl/branch_stat_counters.sv
// Retired-branch statistics: total and taken counters with enable, clear and
// snapshot control, exposed over a single-cycle-ack Wishbone slave.
module branch_stat_counters
    import branch_stat_counters_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk_core,
    input  logic        rstn,
    input  logic        i_br_valid,
    input  logic        i_br_taken,
    input  logic [4:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic [31:0] o_branches,
    output logic [31:0] o_branches_taken
);

    logic        r_ack;
    logic [31:0] r_rdt;
    logic        r_en;
    logic [31:0] r_snap_br;
    logic [31:0] r_snap_tk;

    logic        w_req;
    logic        w_ctrl_wr;
    logic        w_clr;
    logic        w_snap;
    logic        w_inc_br;
    logic        w_inc_tk;
    logic [31:0] w_rd_mux;
    logic        w_unused_bits;

    // A request is accepted only while no ack is outstanding, so a held
    // strobe yields one ack every second cycle.
    assign w_req     = i_wb_cyc & i_wb_stb & ~r_ack;
    assign w_ctrl_wr = w_req & i_wb_we & i_wb_sel[0] & adr_hit(i_wb_adr, ADR_CTRL);
    assign w_clr     = w_ctrl_wr & i_wb_dat[CTRL_CLR];
    assign w_snap    = w_ctrl_wr & i_wb_dat[CTRL_SNAP];

    assign w_inc_br  = r_en & i_br_valid;
    assign w_inc_tk  = r_en & i_br_valid & i_br_taken;

    assign w_unused_bits = ^{i_wb_adr[1:0], i_wb_dat[31:3], i_wb_sel[3:1]};

    stat_counter32 #(.SATURATE(SATURATE)) u_br (
        .clk_core (clk_core),
        .rstn     (rstn),
        .inc      (w_inc_br),
        .clr      (w_clr),
        .count    (o_branches)
    );

    stat_counter32 #(.SATURATE(SATURATE)) u_tk (
        .clk_core (clk_core),
        .rstn     (rstn),
        .inc      (w_inc_tk),
        .clr      (w_clr),
        .count    (o_branches_taken)
    );

    always_comb begin
        w_rd_mux = 32'h0;
        if (adr_hit(i_wb_adr, ADR_BRANCHES)) begin
            w_rd_mux = o_branches;
        end else if (adr_hit(i_wb_adr, ADR_TAKEN)) begin
            w_rd_mux = o_branches_taken;
        end else if (adr_hit(i_wb_adr, ADR_CTRL)) begin
            w_rd_mux = {31'h0, r_en};
        end else if (adr_hit(i_wb_adr, ADR_SNAP_BR)) begin
            w_rd_mux = r_snap_br;
        end else if (adr_hit(i_wb_adr, ADR_SNAP_TK)) begin
            w_rd_mux = r_snap_tk;
        end
    end

    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn) begin
            r_ack <= 1'b0;
            r_rdt <= 32'h0;
        end else begin
            r_ack <= w_req;
            r_rdt <= w_req ? w_rd_mux : 32'h0;
        end
    end

    // Snapshots take the counter values before this edge's increment or clear.
    always_ff @(posedge clk_core or negedge rstn) begin
        if (!rstn) begin
            r_en      <= 1'b1;
            r_snap_br <= 32'h0;
            r_snap_tk <= 32'h0;
        end else begin
            if (w_ctrl_wr) begin
                r_en <= i_wb_dat[CTRL_EN];
            end
            if (w_snap) begin
                r_snap_br <= o_branches;
                r_snap_tk <= o_branches_taken;
            end
        end
    end

    assign o_wb_ack = r_ack;
    assign o_wb_rdt = r_rdt;

endmodule

// File: tb/tb_branch_stat_counters.sv
// Directed bench for branch_stat_counters: one saturating and one wrapping
// instance share stimulus; expected values are hand-derived constants.
module tb_branch_stat_counters;

    logic        clk_core;
    logic        rstn;
    logic        i_br_valid;
    logic        i_br_taken;
    logic [4:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic [31:0] o_branches;
    logic [31:0] o_branches_taken;
    logic [31:0] w_wb_rdt;
    logic        w_wb_ack;
    logic [31:0] w_branches;
    logic [31:0] w_branches_taken;

    int n_cmp;
    int n_fail;

    branch_stat_counters dut (
        .clk_core         (clk_core),
        .rstn             (rstn),
        .i_br_valid       (i_br_valid),
        .i_br_taken       (i_br_taken),
        .i_wb_adr         (i_wb_adr),
        .i_wb_dat         (i_wb_dat),
        .i_wb_sel         (i_wb_sel),
        .i_wb_we          (i_wb_we),
        .i_wb_cyc         (i_wb_cyc),
        .i_wb_stb         (i_wb_stb),
        .o_wb_rdt         (o_wb_rdt),
        .o_wb_ack         (o_wb_ack),
        .o_branches       (o_branches),
        .o_branches_taken (o_branches_taken)
    );

    branch_stat_counters #(.SATURATE(1'b0)) dut_w (
        .clk_core         (clk_core),
        .rstn             (rstn),
        .i_br_valid       (i_br_valid),
        .i_br_taken       (i_br_taken),
        .i_wb_adr         (i_wb_adr),
        .i_wb_dat         (i_wb_dat),
        .i_wb_sel         (i_wb_sel),
        .i_wb_we          (i_wb_we),
        .i_wb_cyc         (i_wb_cyc),
        .i_wb_stb         (i_wb_stb),
        .o_wb_rdt         (w_wb_rdt),
        .o_wb_ack         (w_wb_ack),
        .o_branches       (w_branches),
        .o_branches_taken (w_branches_taken)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All drive tasks start and end at posedge+1, away from the active edge.
    task automatic br_cycle(input logic v, input logic t);
        i_br_valid = v;
        i_br_taken = t;
        @(posedge clk_core);
        #1;
        i_br_valid = 1'b0;
        i_br_taken = 1'b0;
    endtask

    task automatic wb_access(input string tag, input logic [4:0] adr, input logic we,
                             input logic [31:0] dat, input logic [3:0] sel,
                             input logic v, input logic t, output logic [31:0] rdata);
        logic got;
        got = 1'b0;
        rdata = 32'hx;
        i_wb_adr = adr;
        i_wb_we = we;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_br_valid = v;
        i_br_taken = t;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_core);
            #1;
            i_br_valid = 1'b0;
            i_br_taken = 1'b0;
            if (o_wb_ack) begin
                got = 1'b1;
                rdata = o_wb_rdt;
                break;
            end
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we = 1'b0;
        check({tag, "_ack"}, {31'h0, got}, 32'h1);
    endtask

    task automatic wb_write(input string tag, input logic [4:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic v, input logic t);
        logic [31:0] dummy;
        wb_access(tag, adr, 1'b1, dat, sel, v, t, dummy);
    endtask

    task automatic wb_read_check(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_access(tag, adr, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, rd);
        check(tag, rd, exp);
    endtask

    initial begin
        int acks;
        int back_to_back;
        logic prev_ack;
        n_cmp = 0;
        n_fail = 0;
        rstn = 1'b0;
        i_br_valid = 1'b0;
        i_br_taken = 1'b0;
        i_wb_adr = '0;
        i_wb_dat = '0;
        i_wb_sel = '0;
        i_wb_we = 1'b0;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_core);
        #1;
        check("rst_branches", o_branches, 32'h0);
        check("rst_taken", o_branches_taken, 32'h0);
        check("rst_ack", {31'h0, o_wb_ack}, 32'h0);
        check("rst_rdt", o_wb_rdt, 32'h0);
        rstn = 1'b1;
        wb_read_check("rst_ctrl", 5'h08, 32'h1);

        // Ten branches, taken alternating 1/0
        for (int i = 0; i < 10; i++) br_cycle(1'b1, (i % 2) == 0);
        check("cnt_branches", o_branches, 32'd10);
        check("cnt_taken", o_branches_taken, 32'd5);
        wb_read_check("rd_branches", 5'h00, 32'd10);
        wb_read_check("rd_taken", 5'h04, 32'd5);
        wb_read_check("rd_taken_lowbits", 5'h07, 32'd5);

        // Disable, then branches must not count
        wb_write("wr_en0", 5'h08, 32'h0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) br_cycle(1'b1, 1'b1);
        check("dis_branches", o_branches, 32'd10);
        check("dis_taken", o_branches_taken, 32'd5);
        wb_read_check("dis_ctrl", 5'h08, 32'h0);
        wb_write("wr_en1", 5'h08, 32'h1, 4'hF, 1'b0, 1'b0);
        br_cycle(1'b1, 1'b1);
        check("resume_branches", o_branches, 32'd11);
        check("resume_taken", o_branches_taken, 32'd6);
        br_cycle(1'b0, 1'b1);
        check("taken_no_valid", o_branches_taken, 32'd6);

        // Build 20/7, then SNAP+CLR alongside a taken branch
        br_cycle(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) br_cycle(1'b1, 1'b0);
        check("pre_snap_branches", o_branches, 32'd20);
        check("pre_snap_taken", o_branches_taken, 32'd7);
        wb_write("wr_snapclr", 5'h08, 32'h7, 4'hF, 1'b1, 1'b1);
        check("clr_branches", o_branches, 32'h0);
        check("clr_taken", o_branches_taken, 32'h0);
        wb_read_check("snap_br", 5'h10, 32'd20);
        wb_read_check("snap_tk", 5'h14, 32'd7);
        wb_read_check("ctrl_pulses_read0", 5'h08, 32'h1);

        // SNAP alone: old values captured, concurrent increment still lands
        br_cycle(1'b1, 1'b1);
        br_cycle(1'b1, 1'b1);
        br_cycle(1'b1, 1'b0);
        wb_write("wr_snap", 5'h08, 32'h5, 4'hF, 1'b1, 1'b1);
        check("snap_live_br", o_branches, 32'd4);
        check("snap_live_tk", o_branches_taken, 32'd3);
        wb_read_check("snap2_br", 5'h10, 32'd3);
        wb_read_check("snap2_tk", 5'h14, 32'd2);

        // Writes to RO registers and CTRL without sel[0] are ignored
        wb_write("wr_ro", 5'h00, 32'h0, 4'hF, 1'b0, 1'b0);
        wb_write("wr_snapro", 5'h10, 32'h0, 4'hF, 1'b0, 1'b0);
        wb_write("wr_nosel", 5'h08, 32'h2, 4'hE, 1'b0, 1'b0);
        check("ro_branches", o_branches, 32'd4);
        wb_read_check("ro_snap_br", 5'h10, 32'd3);
        br_cycle(1'b1, 1'b0);
        check("nosel_en_kept", o_branches, 32'd5);
        wb_read_check("rd_ctrl_en", 5'h08, 32'h1);

        // Strobe held for six cycles: one-cycle acks every second cycle
        acks = 0;
        back_to_back = 0;
        prev_ack = 1'b0;
        i_wb_adr = 5'h00;
        i_wb_we = 1'b0;
        i_wb_sel = 4'hF;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_core);
            #1;
            if (o_wb_ack) begin
                acks++;
                if (prev_ack) back_to_back++;
            end
            prev_ack = o_wb_ack;
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        check("held_acks", acks, 32'd3);
        check("held_ack_width", back_to_back, 32'd0);
        @(posedge clk_core);
        #1;
        check("held_ack_drop", {31'h0, o_wb_ack}, 32'h0);
        wb_read_check("rd_rsvd_0c", 5'h0C, 32'h0);
        wb_read_check("rd_rsvd_1c", 5'h1C, 32'h0);

        // Top of range: saturate vs wrap
        force dut.u_br.r_count = 32'hFFFF_FFFE;
        force dut_w.u_br.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.u_br.r_count;
        release dut_w.u_br.r_count;
        for (int i = 0; i < 3; i++) br_cycle(1'b1, 1'b0);
        check("sat_branches", o_branches, 32'hFFFF_FFFF);
        check("wrap_branches", w_branches, 32'h0000_0001);
        check("sat_taken", o_branches_taken, 32'd3);

        // Reset during a transfer, before its ack
        i_wb_adr = 5'h00;
        i_wb_we = 1'b0;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        #2;
        rstn = 1'b0;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        #1;
        check("midrst_ack", {31'h0, o_wb_ack}, 32'h0);
        check("midrst_branches", o_branches, 32'h0);
        check("midrst_taken", o_branches_taken, 32'h0);
        @(posedge clk_core);
        #1;
        rstn = 1'b1;
        @(posedge clk_core);
        #1;
        check("postrst_ack", {31'h0, o_wb_ack}, 32'h0);
        wb_read_check("postrst_ctrl", 5'h08, 32'h1);
        wb_read_check("postrst_snap_br", 5'h10, 32'h0);
        wb_read_check("postrst_snap_tk", 5'h14, 32'h0);
        br_cycle(1'b1, 1'b1);
        check("postrst_count", o_branches, 32'd1);
        check("postrst_count_tk", o_branches_taken, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
